// File: rtl/sme_pkg.sv
// Shared types and helpers for the string-matcher match-compaction stages.
package sme_pkg;

  localparam int SME_LANES = 16;
  localparam int SME_ID_W  = 16;

  typedef logic [SME_LANES-1:0][SME_ID_W-1:0] sme_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    TERM  = 2'd2
  } sme_state_e;

  // Terminator payload: overflow flag in the MSB, match count below it.
  function automatic logic [SME_ID_W-1:0] term_payload(input logic ovf,
                                                       input logic [SME_ID_W-1:0] cnt);
    return {ovf, cnt[SME_ID_W-2:0]};
  endfunction

endpackage

// File: rtl/lane_prio_enc.sv
// Lowest-set-bit priority encoder over a lane mask: onehot, index and a
// flag that exactly one lane remains.
module lane_prio_enc #(
  parameter int LANES = 16,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic [LANES-1:0] mask_i,
  output logic [LANES-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             single_o
);

  // Ascending scan; a lane wins only if no lower lane was set.
  always_comb begin
    logic found;
    found    = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    for (int i = 0; i < LANES; i++) begin
      onehot_o[i] = mask_i[i] & ~found;
      idx_o       = idx_o | ({IDX_W{onehot_o[i]}} & IDX_W'(i));
      found       = found | mask_i[i];
    end
  end

  assign single_o = (mask_i != '0) && ((mask_i & (mask_i - LANES'(1))) == '0);

endmodule

// File: rtl/sme_match_serializer.sv
// Compacts 16-lane rule-ID words into a one-ID-per-cycle stream and closes
// every packet with a terminator beat carrying the match count.
module sme_match_serializer
  import sme_pkg::*;
#(
  parameter int LANES       = SME_LANES,
  parameter int ID_W        = SME_ID_W,
  parameter int MAX_MATCHES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES*ID_W-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  in_ready,
  output logic [ID_W-1:0]       m_rule_id,
  output logic                  m_term,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [15:0]           sop_err_cnt
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  sme_state_e                 state_q, state_d;
  logic [LANES-1:0][ID_W-1:0] data_q, data_d, in_lanes_s;
  logic [LANES-1:0]           mask_q, mask_d, in_mask_s;
  logic [LANES-1:0]           sel_q, nxt_onehot_s;
  logic                       single_q, nxt_single_s;
  logic [IDX_W-1:0]           nxt_idx_s;
  logic                       held_eop_q, held_eop_d;
  logic                       ovf_q, ovf_d, open_q, open_d;
  logic [ID_W-1:0]            pkt_cnt_q, pkt_cnt_d;
  logic [15:0]                sop_err_q, sop_err_d;
  logic                       m_valid_q, m_valid_d, m_term_q, m_term_d;
  logic [ID_W-1:0]            m_rule_id_q, m_rule_id_d;
  logic                       fire_s, capped_s, fast_s, accept_s;

  assign in_lanes_s = in_data;

  // Per-lane occupancy of the incoming word.
  always_comb begin
    in_mask_s = '0;
    for (int i = 0; i < LANES; i++) begin
      in_mask_s[i] = (in_lanes_s[i] != '0);
    end
  end

  assign fire_s   = m_valid_q && m_ready;
  assign capped_s = (state_q == DRAIN) && (pkt_cnt_q == ID_W'(MAX_MATCHES));
  assign fast_s   = (state_q == DRAIN) && single_q && m_ready && !held_eop_q && !capped_s;
  assign in_ready = !rst && ((state_q == IDLE) || fast_s);
  assign accept_s = in_valid && in_ready;

  // Next-state: drain/terminate the held word, then overlay a new accept.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    data_d     = data_q;
    held_eop_d = held_eop_q;
    pkt_cnt_d  = pkt_cnt_q;
    ovf_d      = ovf_q;
    open_d     = open_q;
    sop_err_d  = sop_err_q;
    case (state_q)
      IDLE: state_d = IDLE;
      DRAIN: begin
        if (capped_s || fire_s) begin
          mask_d = mask_q & ~sel_q;
          if (capped_s) begin
            ovf_d = 1'b1;
          end else begin
            pkt_cnt_d = (pkt_cnt_q == {ID_W{1'b1}}) ? pkt_cnt_q : pkt_cnt_q + ID_W'(1);
          end
          if (single_q) begin
            state_d = held_eop_q ? TERM : IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      TERM: begin
        if (fire_s) begin
          state_d   = IDLE;
          pkt_cnt_d = '0;
          ovf_d     = 1'b0;
          open_d    = 1'b0;
        end else begin
          state_d = TERM;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept_s) begin
      data_d     = in_lanes_s;
      mask_d     = in_mask_s;
      held_eop_d = in_eop;
      open_d     = !in_eop;
      if (in_sop) begin
        pkt_cnt_d = '0;
        ovf_d     = 1'b0;
        if (open_q) begin
          sop_err_d = (sop_err_q == 16'hFFFF) ? sop_err_q : sop_err_q + 16'd1;
        end else begin
          sop_err_d = sop_err_q;
        end
      end else begin
        sop_err_d = sop_err_q;
      end
      if (in_mask_s != '0) begin
        state_d = DRAIN;
      end else begin
        state_d = in_eop ? TERM : IDLE;
      end
    end else begin
      held_eop_d = held_eop_q;
    end
  end

  lane_prio_enc #(.LANES(LANES), .IDX_W(IDX_W)) u_prio (
    .mask_i   (mask_d),
    .onehot_o (nxt_onehot_s),
    .idx_o    (nxt_idx_s),
    .single_o (nxt_single_s)
  );

  // Output beat for the upcoming cycle, derived from the next state so the
  // outputs leave the flops directly and hold while stalled.
  always_comb begin
    m_valid_d   = 1'b0;
    m_term_d    = 1'b0;
    m_rule_id_d = '0;
    case (state_d)
      IDLE: m_valid_d = 1'b0;
      DRAIN: begin
        m_valid_d   = (pkt_cnt_d != ID_W'(MAX_MATCHES));
        m_rule_id_d = data_d[nxt_idx_s];
      end
      TERM: begin
        m_valid_d   = 1'b1;
        m_term_d    = 1'b1;
        m_rule_id_d = term_payload(ovf_d, pkt_cnt_d);
      end
      default: m_valid_d = 1'b0;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      single_q    <= 1'b0;
      held_eop_q  <= 1'b0;
      pkt_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      open_q      <= 1'b0;
      sop_err_q   <= 16'd0;
      m_valid_q   <= 1'b0;
      m_term_q    <= 1'b0;
      m_rule_id_q <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      data_q      <= data_d;
      sel_q       <= nxt_onehot_s;
      single_q    <= nxt_single_s;
      held_eop_q  <= held_eop_d;
      pkt_cnt_q   <= pkt_cnt_d;
      ovf_q       <= ovf_d;
      open_q      <= open_d;
      sop_err_q   <= sop_err_d;
      m_valid_q   <= m_valid_d;
      m_term_q    <= m_term_d;
      m_rule_id_q <= m_rule_id_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_term      = m_term_q;
  assign m_rule_id   = m_rule_id_q;
  assign sop_err_cnt = sop_err_q;

endmodule

// File: tb/tb_sme_match_serializer.sv
// Self-checking bench: table vectors, hand-written corner sequences and a
// randomized run scored against a queue-based reference model.
module tb_sme_match_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default cap of 256
  logic         rst, in_valid, in_sop, in_eop, in_ready, m_term, m_valid, m_ready;
  logic [255:0] in_data;
  logic [15:0]  m_rule_id, sop_err_cnt;
  // DUT B: cap of 4
  logic         b_rst, b_in_valid, b_in_sop, b_in_eop, b_in_ready, b_m_term, b_m_valid, b_m_ready;
  logic [255:0] b_in_data;
  logic [15:0]  b_m_rule_id, b_sop_err_cnt;

  sme_match_serializer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_ready(in_ready), .m_rule_id(m_rule_id), .m_term(m_term),
    .m_valid(m_valid), .m_ready(m_ready), .sop_err_cnt(sop_err_cnt)
  );

  sme_match_serializer #(.MAX_MATCHES(4)) dut_cap (
    .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_sop(b_in_sop),
    .in_eop(b_in_eop), .in_ready(b_in_ready), .m_rule_id(b_m_rule_id), .m_term(b_m_term),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .sop_err_cnt(b_sop_err_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (expected beat stream) ----------------
  logic [16:0] expq[$];
  int          m_open = 0, m_cnt = 0, m_sop_err = 0;
  bit          m_ovf = 1'b0;
  int          n_id = 0, n_term = 0;
  logic [15:0] last_term = 16'd0;
  int          mr_mode = 0;

  task automatic model_accept();
    logic [15:0] id;
    logic [15:0] p;
    if (in_sop) begin
      if (m_open != 0 && m_sop_err < 65535) m_sop_err++;
      m_cnt = 0;
      m_ovf = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      id = in_data[i*16 +: 16];
      if (id != 16'd0) begin
        if (m_cnt < 256) begin
          expq.push_back({1'b0, id});
          m_cnt++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (in_eop) begin
      p     = 16'(m_cnt);
      p[15] = m_ovf;
      expq.push_back({1'b1, p});
      m_cnt = 0;
      m_ovf = 1'b0;
    end
    m_open = in_eop ? 0 : 1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      m_open = 0; m_cnt = 0; m_ovf = 1'b0; m_sop_err = 0;
    end else begin
      if (m_valid) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL stream: unexpected beat term=%0b id=%h", m_term, m_rule_id);
        end else begin
          chk("stream", {15'd0, m_term, m_rule_id}, {15'd0, expq[0]});
        end
        if (m_ready) begin
          if (expq.size() != 0) void'(expq.pop_front());
          if (m_term) begin n_term++; last_term = m_rule_id; end
          else n_id++;
        end
      end
      if (in_valid && in_ready) model_accept();
    end
  end

  always @(posedge clk) begin
    #1;
    if (mr_mode == 1) m_ready = ($urandom_range(0, 3) != 0);
    else if (mr_mode == 2) m_ready = ~m_ready;
  end

  // ---------------- helpers ----------------
  function automatic logic [255:0] mk(input logic [15:0] mask, input logic [15:0] base);
    logic [255:0] d;
    d = '0;
    for (int i = 0; i < 16; i++) if (mask[i]) d[i*16 +: 16] = base + 16'(i);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [255:0] d, input logic s, input logic e);
    int n;
    n = 0;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin total++; bad++; $display("FAIL send_timeout: in_ready stuck low"); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk); #1;
    while ((expq.size() != 0 || m_valid) && n < 600) begin @(negedge clk); #1; n++; end
    chk("drain_done", {31'd0, (n < 600)}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_term", {31'd0, m_term}, 32'd0);
    chk("rst_rule_id", {16'd0, m_rule_id}, 32'd0);
    chk("rst_sop_err", {16'd0, sop_err_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [15:0] mask;
    logic [15:0] base;
    int          exp_ids;
    logic [15:0] exp_term;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int id0, t0, rem, nb;
    logic [15:0] bids[$];
    logic [15:0] bterm;
    logic [255:0] d;
    bit open_tb;
    logic s, e;

    tbl[0] = '{16'h0000, 16'h0000, 0,  16'h0000};
    tbl[1] = '{16'h0208, 16'h0100, 2,  16'h0002};
    tbl[2] = '{16'hFFFF, 16'h1000, 16, 16'h0010};
    tbl[3] = '{16'h8000, 16'h00F0, 1,  16'h0001};
    tbl[4] = '{16'h00FF, 16'h0001, 8,  16'h0008};
    tbl[5] = '{16'h5555, 16'h2000, 8,  16'h0008};

    in_data = '0; m_ready = 1'b1;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_sop = 1'b0; b_in_eop = 1'b0;
    b_in_data = '0; b_m_ready = 1'b1;
    do_reset();

    // Latency: lanes 3 and 9, beats on consecutive cycles from N+1
    d = '0; d[3*16 +: 16] = 16'h0101; d[9*16 +: 16] = 16'h0202;
    send_word(d, 1'b1, 1'b1);
    @(negedge clk);
    chk("lat_b1_valid", {31'd0, m_valid}, 32'd1);
    chk("lat_b1", {15'd0, m_term, m_rule_id}, {15'd0, 1'b0, 16'h0101});
    @(negedge clk);
    chk("lat_b2", {15'd0, m_term, m_rule_id}, {15'd0, 1'b0, 16'h0202});
    @(negedge clk);
    chk("lat_term_valid", {31'd0, m_valid}, 32'd1);
    chk("lat_term", {15'd0, m_term, m_rule_id}, {15'd0, 1'b1, 16'h0002});
    @(negedge clk);
    chk("lat_idle", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1;

    // Table of single-word packets
    for (int k = 0; k < 6; k++) begin
      id0 = n_id; t0 = n_term;
      send_word(mk(tbl[k].mask, tbl[k].base), 1'b1, 1'b1);
      wait_drain();
      chk($sformatf("tbl%0d_ids", k), 32'(n_id - id0), 32'(tbl[k].exp_ids));
      chk($sformatf("tbl%0d_terms", k), 32'(n_term - t0), 32'd1);
      chk($sformatf("tbl%0d_term", k), {16'd0, last_term}, {16'd0, tbl[k].exp_term});
    end

    // Three all-empty words: one terminator of zero
    id0 = n_id; t0 = n_term;
    send_word('0, 1'b1, 1'b0);
    send_word('0, 1'b0, 1'b0);
    send_word('0, 1'b0, 1'b1);
    wait_drain();
    chk("empty_ids", 32'(n_id - id0), 32'd0);
    chk("empty_terms", 32'(n_term - t0), 32'd1);
    chk("empty_term", {16'd0, last_term}, 32'd0);

    // 16 lanes with m_ready toggling; in_ready only on the last-ID fire
    id0 = n_id;
    mr_mode = 2;
    send_word(mk(16'hFFFF, 16'h0A00), 1'b1, 1'b0);
    nb = 0;
    rem = 16;
    while (nb < 200) begin
      @(negedge clk); #1;
      rem = 16 - (n_id - id0) + ((m_valid && m_ready) ? 1 : 0);
      chk("t16_in_ready", {31'd0, in_ready}, {31'd0, (rem == 1 && m_ready)});
      if (rem == 1 && m_ready) break;
      nb++;
    end
    chk("t16_done", {31'd0, (nb < 200)}, 32'd1);
    @(posedge clk); #1;
    mr_mode = 0; m_ready = 1'b1;
    send_word('0, 1'b0, 1'b1);
    wait_drain();
    chk("t16_ids", 32'(n_id - id0), 32'd16);
    chk("t16_term", {16'd0, last_term}, 32'h0010);

    // sop while open
    do_reset();
    id0 = n_id;
    d = '0; d[15:0] = 16'h0005;
    send_word(d, 1'b1, 1'b0);
    d = '0; d[15:0] = 16'h0007; d[31:16] = 16'h0008;
    send_word(d, 1'b1, 1'b1);
    wait_drain();
    chk("soperr_cnt", {16'd0, sop_err_cnt}, 32'd1);
    chk("soperr_term", {16'd0, last_term}, 32'h0002);
    chk("soperr_ids", 32'(n_id - id0), 32'd3);

    // Reset while draining with 5 IDs left
    id0 = n_id;
    m_ready = 1'b0;
    send_word(mk(16'h00FF, 16'h0300), 1'b1, 1'b1);
    m_ready = 1'b1;
    tick(); tick(); tick();
    m_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_in_ready_after", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_fired", 32'(n_id - id0), 32'd3);
    @(posedge clk); #1;
    m_ready = 1'b1;
    send_word(mk(16'h0003, 16'h0400), 1'b1, 1'b1);
    wait_drain();
    chk("mid_rst_new_term", {16'd0, last_term}, 32'h0002);

    // Cap of 256 on DUT A across a 20-word packet
    id0 = n_id;
    send_word(mk(16'hFFFF, 16'h0100), 1'b1, 1'b0);
    for (int k = 0; k < 18; k++) send_word(mk(16'hFFFF, 16'h0200), 1'b0, 1'b0);
    send_word(mk(16'hFFFF, 16'h0300), 1'b0, 1'b1);
    wait_drain();
    chk("capA_ids", 32'(n_id - id0), 32'd256);
    chk("capA_term", {16'd0, last_term}, 32'h8100);

    // Cap of 4 on DUT B with 6 non-zero lanes
    tick(); tick();
    b_rst = 1'b0;
    b_in_data = mk(16'h003F, 16'h0700); b_in_sop = 1'b1; b_in_eop = 1'b1; b_in_valid = 1'b1;
    @(negedge clk);
    chk("capB_in_ready", {31'd0, b_in_ready}, 32'd1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    nb = 0; bterm = 16'hFFFF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (b_m_valid && b_m_ready) begin
        if (b_m_term) begin nb++; bterm = b_m_rule_id; end
        else bids.push_back(b_m_rule_id);
      end
    end
    chk("capB_nids", 32'(bids.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < bids.size()) chk($sformatf("capB_id%0d", i), {16'd0, bids[i]}, {16'd0, 16'h0700 + 16'(i)});
    chk("capB_nterm", 32'(nb), 32'd1);
    chk("capB_term", {16'd0, bterm}, 32'h8004);
    @(posedge clk); #1;

    // Randomized packets against the model
    mr_mode = 1;
    open_tb = 1'b0;
    for (int k = 0; k < 250; k++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      s = !open_tb || ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 2) == 0);
      d = '0;
      if ($urandom_range(0, 7) != 0)
        for (int i = 0; i < 16; i++)
          if ($urandom_range(0, 3) == 0) d[i*16 +: 16] = 16'($urandom_range(1, 65535));
      send_word(d, s, e);
      open_tb = !e;
    end
    if (open_tb) send_word('0, 1'b0, 1'b1);
    mr_mode = 0; m_ready = 1'b1;
    wait_drain();
    chk("rand_sop_err", {16'd0, sop_err_cnt}, 32'(m_sop_err));
    chk("rand_queue_empty", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
